// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one subtract-and-restore step per clock.
// Optional two's-complement mode when DIV_SIGNED_EN is defined.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   r_sh, t;
    logic [WIDTH-1:0] a_mag, b_mag;
`ifdef DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             a_neg, b_neg;
`endif

    always_comb begin
`ifdef DIV_SIGNED_EN
        a_neg = signed_op & dividend[WIDTH-1];
        b_neg = signed_op & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
`else
        a_mag = dividend;
        b_mag = divisor;
`endif
        r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        t    = r_sh - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                dbz_d = 1'b0;
                cnt_d = CW'(WIDTH);
                r_d   = '0;
                if (divisor == '0) begin
                    // Raw dividend is kept so ZERO can return it unmodified.
                    q_d     = dividend;
                    state_d = ZERO;
                end else begin
                    q_d     = a_mag;
                    dvs_d   = b_mag;
`ifdef DIV_SIGNED_EN
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!t[WIDTH]) begin
                    r_d = t;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_sh;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) state_d = FIN;
            end
            FIN: begin
`ifdef DIV_SIGNED_EN
                // -2^(W-1)/-1 falls out naturally: magnitude 2^(W-1), no negation.
                quo_d = qneg_q ? (~q_q + 1'b1) : q_q;
                rem_d = rneg_q ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
`else
                quo_d = q_q;
                rem_d = r_q[WIDTH-1:0];
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ZERO: begin
                quo_d   = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider against an arithmetic model.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         signed_op = 1'b0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    int checks = 0, errors = 0;
    logic [W-1:0] prev_q = '0, prev_r = '0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truncating division from plain integer arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        int sa, sb, iq, ir;
        z = (b == 0);
        if (b == 0) begin
            q = '1; r = a;
        end else if (!sg) begin
            q = a / b; r = a % b;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(1 << (W-1)) && sb == -1) begin
                iq = sa; ir = 0;
            end else begin
                iq = sa / sb; ir = sa % sb;
            end
            q = iq[W-1:0]; r = ir[W-1:0];
        end
    endtask

    // Called at a negedge (possibly the done cycle of the previous op).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input bit ign);
        logic [W-1:0] eq, er;
        logic ez;
        int cyc, lat;
        model(a, b, sg, eq, er, ez);
        lat = (b == 0) ? 1 : W + 1;
        start = 1'b1; dividend = a; divisor = b; signed_op = sg;
        @(negedge clk);
        cyc = 1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("done_low_first", done, 1'b0);
        chk("q_held", quotient, prev_q);
        chk("r_held", remainder, prev_r);
        while (!done && cyc < 60) begin
            if (ign && cyc == 3) begin
                start = 1'b1; dividend = a ^ 8'h5A; divisor = b + 8'd3;
            end else if (cyc == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc - 1, lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        chk("busy_at_done", busy, 1'b0);
        prev_q = eq; prev_r = er;
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic sg;
        int gap;
        #12;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd7, 1'b0, 1'b0);
        chk("100div7_q", quotient, 14);
        run_op(8'd255, 8'd1, 1'b0, 1'b0);
        run_op(8'd3, 8'd200, 1'b0, 1'b0);
        run_op(8'd5, 8'd0, 1'b0, 1'b0);
        chk("5div0_q", quotient, 8'hFF);
        run_op(8'd6, 8'd3, 1'b0, 1'b0);
        chk("dbz_cleared", div_by_zero, 0);

        // Ignored start mid-operation, then asynchronous reset.
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk); start = 1'b0;
        chk("ign_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        prev_q = '0; prev_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd9, 8'd4, 1'b0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op(8'hF9, 8'd2, 1'b1, 1'b0);
        chk("m7div2_q", quotient, 8'hFD);
        run_op(8'h80, 8'hFF, 1'b1, 1'b0);
        chk("ovf_q", quotient, 8'h80);
        run_op(8'd7, 8'hFE, 1'b1, 1'b0);
        run_op(8'hF9, 8'd2, 1'b0, 1'b0);
        run_op(8'hF9, 8'd0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'h80;
`ifdef DIV_SIGNED_EN
            sg = 1'($urandom);
`else
            sg = 1'b0;
`endif
            run_op(a, b, sg, (b != 0) && ($urandom_range(0, 2) == 0));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
